// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRValid;
  logic [31:0] ImemRData;

  modport master (output ImemReq, ImemAddr, input ImemGnt, ImemRValid, ImemRData);
  modport slave  (input ImemReq, ImemAddr, output ImemGnt, ImemRValid, ImemRData);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: in-order imem requests, 2-entry response buffer, decode register with stall/flush/redirect.
// Define FETCH_PERF_EN to add the RedirectCount output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         PCSrcE,
  input  logic [31:0]  PCTargetE,
  fetch_unit_if.master imem,
  output logic [31:0]  InstrD,
  output logic [31:0]  PCD,
  output logic [31:0]  PCPlus4D,
  output logic         ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  RedirectCount
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcF_q, pcF_d;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] instrBuf_q [2];
  logic [31:0] instrBuf_d [2];
  logic [31:0] pcBuf_q [2];
  logic [31:0] pcBuf_d [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcPlus4D_q, pcPlus4D_d;
  logic        validD_q, validD_d;

  logic        handshake, respAccept, respDrain, pop, pushIdx;
  logic [2:0]  inFlight;
  logic [1:0]  owed;
  logic [31:0] respPc;

  assign inFlight      = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem.ImemReq  = (state_q == RUN) && !StallF && !PCSrcE && (inFlight < 3'd2);
  assign imem.ImemAddr = pcF_q;
  assign handshake     = imem.ImemReq && imem.ImemGnt;
  assign respAccept    = (state_q == RUN) && imem.ImemRValid && (outstanding_q != 2'd0);
  assign respDrain     = (state_q == DRAIN) && imem.ImemRValid && (drop_q != 2'd0);
  // In-flight requests are contiguous since the last redirect, so the oldest one's PC follows from PCF.
  assign respPc        = pcF_q - {28'd0, outstanding_q, 2'b00};
  assign pop           = !FlushD && !PCSrcE && !StallD && (count_q != 2'd0);
  assign pushIdx       = head_q ^ count_q[0];
  assign owed          = drop_q + outstanding_q - {1'b0, (respAccept | respDrain)};

  always_comb begin
    state_d       = state_q;
    pcF_d         = pcF_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    head_d        = head_q;
    count_d       = count_q;
    instrBuf_d    = instrBuf_q;
    pcBuf_d       = pcBuf_q;
    instrD_d      = instrD_q;
    pcD_d         = pcD_q;
    pcPlus4D_d    = pcPlus4D_q;
    validD_d      = validD_q;

    if (PCSrcE) begin
      pcF_d         = PCTargetE;
      outstanding_d = 2'd0;
      drop_d        = owed;
      count_d       = 2'd0;
      head_d        = 1'b0;
      state_d       = (owed != 2'd0) ? DRAIN : RUN;
    end else begin
      unique case (state_q)
        BOOT:    state_d = RUN;
        DRAIN: begin
          if (respDrain) drop_d = drop_q - 2'd1;
          if (drop_d == 2'd0) state_d = RUN;
        end
        default: state_d = state_q;
      endcase
      if (handshake) pcF_d = pcF_q + 32'd4;
      outstanding_d = outstanding_q + {1'b0, handshake} - {1'b0, respAccept};
      if (respAccept) begin
        instrBuf_d[pushIdx] = imem.ImemRData;
        pcBuf_d[pushIdx]    = respPc;
      end
      if (pop) head_d = ~head_q;
      count_d = count_q + {1'b0, respAccept} - {1'b0, pop};
    end

    // Kill beats stall; a stalled decode register keeps its contents.
    if (FlushD || PCSrcE) begin
      instrD_d = NOP_INSTR;
      validD_d = 1'b0;
    end else if (!StallD) begin
      if (count_q != 2'd0) begin
        instrD_d   = instrBuf_q[head_q];
        pcD_d      = pcBuf_q[head_q];
        pcPlus4D_d = pcBuf_q[head_q] + 32'd4;
        validD_d   = 1'b1;
      end else begin
        instrD_d = NOP_INSTR;
        validD_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pcF_q         <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      head_q        <= 1'b0;
      count_q       <= 2'd0;
      instrBuf_q[0] <= '0;
      instrBuf_q[1] <= '0;
      pcBuf_q[0]    <= '0;
      pcBuf_q[1]    <= '0;
      instrD_q      <= NOP_INSTR;
      pcD_q         <= '0;
      pcPlus4D_q    <= '0;
      validD_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcF_q         <= pcF_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      count_q       <= count_d;
      instrBuf_q    <= instrBuf_d;
      pcBuf_q       <= pcBuf_d;
      instrD_q      <= instrD_d;
      pcD_q         <= pcD_d;
      pcPlus4D_q    <= pcPlus4D_d;
      validD_q      <= validD_d;
    end
  end

  assign InstrD   = instrD_q;
  assign PCD      = pcD_q;
  assign PCPlus4D = pcPlus4D_q;
  assign ValidD   = validD_q;

`ifdef FETCH_PERF_EN
  logic [31:0] redirectCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) redirectCount_q <= '0;
    else if (PCSrcE) redirectCount_q <= redirectCount_q + 32'd1;
  end

  assign RedirectCount = redirectCount_q;
`endif

endmodule
